// File: rtl/gwct_cmd.sv
`timescale 1ns/1ps
// UART command parser: SYNC/CMD/ADDR/[DATA]/CSUM frames drive
// single-cycle register strobes and return an ACK, NAK or read byte.
module gwct_cmd #(
  parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA,
    S_CSUM, S_EXEC, S_RDWAIT, S_RESP
  } state_t;

  localparam logic [7:0]  SYNC   = 8'hA5;
  localparam logic [7:0]  C_WR   = 8'h01;
  localparam logic [7:0]  C_RD   = 8'h02;
  localparam logic [7:0]  ACK    = 8'h06;
  localparam logic [7:0]  NAK    = 8'h15;
  localparam logic [31:0] TO_LIM = TIMEOUT_CYC;

  state_t      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] timer_inc;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  txd_q, txd_d;
  logic        err_q, err_d;
  logic        in_frame;
  logic        known;

  assign timer_inc = timer_q + 32'd1;
  assign known     = (cmd_q == C_WR) || (cmd_q == C_RD);
  assign in_frame  = (state_q == S_CMD) || (state_q == S_ADDR) ||
                     (state_q == S_DATA) || (state_q == S_CSUM);

  always_comb begin
    state_d = state_q;
    timer_d = 32'd0;
    cmd_d   = cmd_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    txd_d   = txd_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == SYNC) state_d = S_CMD;
      end
      S_CMD: begin
        if (rx_valid) begin
          cmd_d   = rx_data;
          csum_d  = rx_data;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_data;
          csum_d  = csum_q ^ rx_data;
          state_d = (cmd_q == C_WR) ? S_DATA : S_CSUM;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          wdata_d = rx_data;
          csum_d  = csum_q ^ rx_data;
          state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_data == csum_q && known) begin
            state_d = S_EXEC;
          end else begin
            txd_d   = NAK;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_EXEC: begin
        if (cmd_q == C_WR) begin
          txd_d   = ACK;
          state_d = S_RESP;
        end else begin
          state_d = S_RDWAIT;
        end
      end
      S_RDWAIT: begin
        txd_d   = reg_rdata;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // silence between frame bytes abandons the frame without a response
    if (in_frame && !rx_valid) begin
      timer_d = timer_inc;
      if (timer_inc >= TO_LIM) begin
        timer_d = 32'd0;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      timer_q <= 32'd0;
      cmd_q   <= 8'h00;
      csum_q  <= 8'h00;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      txd_q   <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cmd_q   <= cmd_d;
      csum_q  <= csum_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      txd_q   <= txd_d;
      err_q   <= err_d;
    end
  end

  assign tx_data   = txd_q;
  assign tx_valid  = (state_q == S_RESP) && tx_ready;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = (state_q == S_EXEC) && (cmd_q == C_WR);
  assign reg_re    = (state_q == S_EXEC) && (cmd_q == C_RD);
  assign frame_err = err_q;

endmodule

// File: doc/gwct_cmd.md
GWCT_CMD -- requirements
Module: gwct_cmd

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 5_000_000, idle clock cycles allowed between bytes of one frame before the frame is abandoned.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rstn  input  1  reset, asynchronous, active-low.
REQ-004 Port: rx_data  input  8  received byte from the UART receiver.
REQ-005 Port: rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
REQ-006 Port: tx_data  output  8  response byte to the UART transmitter.
REQ-007 Port: tx_valid  output  1  one-cycle strobe requesting transmission of tx_data.
REQ-008 Port: tx_ready  input  1  transmitter idle.
REQ-009 Port: reg_addr  output  8  register address of the current command.
REQ-010 Port: reg_wdata  output  8  write data of the current command.
REQ-011 Port: reg_we  output  1  one-cycle register write strobe.
REQ-012 Port: reg_re  output  1  one-cycle register read strobe.
REQ-013 Port: reg_rdata  input  8  read data, valid exactly one cycle after reg_re.
REQ-014 Port: frame_err  output  1  one-cycle pulse on checksum error, unknown command or timeout.

Function
REQ-015 Frame format: SYNC 0xA5, CMD, ADDR, [DATA if CMD=0x01], CSUM; CSUM = CMD ^ ADDR ^ DATA (DATA term omitted for reads).
REQ-016 CMD 0x01 = write, 0x02 = read; any other CMD is unknown.
REQ-017 States: IDLE, CMD, ADDR, DATA, CSUM, EXEC, RDWAIT, RESP.
REQ-018 IDLE: rx_valid with rx_data=0xA5 -> CMD; other bytes discarded, no error.
REQ-019 CMD: capture byte -> ADDR; ADDR: capture into reg_addr -> DATA if write, else CSUM; DATA: capture into reg_wdata -> CSUM.
REQ-020 Unknown CMD is not rejected early; frame is still parsed as a read-length frame (ADDR, CSUM) and then NAKed.
REQ-021 CSUM: checksum match and known CMD -> EXEC; otherwise tx_data=0x15 (NAK), frame_err pulse, -> RESP.
REQ-022 EXEC write: reg_we high exactly one cycle, tx_data=0x06 (ACK), -> RESP.
REQ-023 EXEC read: reg_re high exactly one cycle -> RDWAIT; RDWAIT: tx_data<=reg_rdata -> RESP.
REQ-024 RESP: wait until tx_ready=1, then tx_valid high exactly one cycle with tx_data stable, -> IDLE.
REQ-025 tx_data remains stable from entry to RESP until at least the cycle after tx_valid.
REQ-026 Latency: write ACK tx_valid no earlier than 2 cycles after the CSUM rx_valid; read response no earlier than 3 cycles (tx_ready=1 throughout).
REQ-027 Inter-byte timer: 32-bit counter, cleared on every accepted rx_valid, counts in CMD/ADDR/DATA/CSUM; reaching TIMEOUT_CYC -> frame_err pulse, -> IDLE, no response, no reg strobe.
REQ-028 rx_valid in EXEC/RDWAIT/RESP is ignored (byte dropped, not parsed as SYNC).
REQ-029 A 0xA5 byte inside a frame is data, not resync.
REQ-030 reg_addr and reg_wdata hold their values until overwritten by the next frame's ADDR/DATA byte.
REQ-031 reg_we and reg_re are never high in the same cycle; neither is high outside EXEC.

Reset
REQ-032 On rstn low, immediately: state IDLE, timer 0, tx_valid 0, reg_we 0, reg_re 0, frame_err 0, tx_data 0x00, reg_addr 0x00, reg_wdata 0x00.
REQ-033 Reset mid-frame or mid-RESP abandons the frame; no tx_valid or reg strobe is generated after rstn releases until a new complete frame arrives.

Verification
REQ-034 Write: bytes A5 01 10 3C 2D (2D = 01^10^3C) -> one reg_we with reg_addr=0x10, reg_wdata=0x3C; one tx_valid with tx_data=0x06.
REQ-035 Read: A5 02 22 20, reg_rdata=0x5A in cycle after reg_re -> one reg_re, reg_addr=0x22; tx_valid with tx_data=0x5A.
REQ-036 Bad checksum: A5 01 10 3C 00 -> no reg_we, frame_err pulse, tx_valid with tx_data=0x15; unknown CMD A5 07 00 07 -> same NAK.
REQ-037 Timeout (TIMEOUT_CYC=100): A5 01 then silence 100 cycles -> frame_err pulse, no tx_valid; then A5 02 22 20 is served normally.
REQ-038 Backpressure: tx_ready held 0 for 50 cycles at RESP -> tx_valid asserted only in first cycle tx_ready=1, exactly once; bytes arriving meanwhile dropped.
REQ-039 Reset mid-frame: A5 01 10, pulse rstn low -> all outputs at REQ-032 values; trailing 3C 2D produce no reg_we and no response.
